insn_queue: RTL and testbench

- Small instruction FIFO between the fetch stage and decode.
- Captures (pc, insn) pairs from fetch and presents them to decode with a valid/ready handshake.
- Absorbs decode back-pressure; flushes all in-flight entries on a control-flow redirect.

---
 rtl/insn_queue_pkg.sv | 13 +
 rtl/insn_queue_if.sv | 31 +++
 rtl/insn_queue_ctrl.sv | 77 +++++++
 rtl/insn_queue.sv | 85 ++++++++
 tb/tb_insn_queue.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/insn_queue_pkg.sv
// Shared fetch/decode definitions: the canonical NOP, the instruction memory base
// and the pc/insn packet type passed between the front-end stages.
package insn_queue_pkg;

  localparam logic [31:0] INSN_NOP       = 32'h0000_0013;
  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_pkt_t;

endpackage

// File: rtl/insn_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The master side is the fetch/decode environment; the slave side is the queue.
interface insn_queue_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4,
  parameter int CWIDTH = $clog2(DEPTH) + 1
);

  logic              fetch_valid_i;
  logic [AWIDTH-1:0] fetch_pc_i;
  logic [DWIDTH-1:0] fetch_insn_i;
  logic              fetch_ready_o;
  logic              dec_valid_o;
  logic [AWIDTH-1:0] dec_pc_o;
  logic [DWIDTH-1:0] dec_insn_o;
  logic              dec_ready_i;
  logic              flush_i;
  logic [CWIDTH-1:0] count_o;

  modport master (
    output fetch_valid_i, fetch_pc_i, fetch_insn_i, dec_ready_i, flush_i,
    input  fetch_ready_o, dec_valid_o, dec_pc_o, dec_insn_o, count_o
  );

  modport slave (
    input  fetch_valid_i, fetch_pc_i, fetch_insn_i, dec_ready_i, flush_i,
    output fetch_ready_o, dec_valid_o, dec_pc_o, dec_insn_o, count_o
  );

endinterface

// File: rtl/insn_queue_ctrl.sv
// Pointer, occupancy and push/pop/flush qualification for insn_queue.
// INSN_QUEUE_BYPASS_EN enables the empty-queue zero-latency pass-through.
module insn_queue_ctrl #(
  parameter int DEPTH  = 4,
  parameter int PWIDTH = $clog2(DEPTH),
  parameter int CWIDTH = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic              dec_ready,
  input  logic              flush,
  output logic              push,
  output logic              bypass,
  output logic              fetch_ready,
  output logic              dec_valid,
  output logic [PWIDTH-1:0] wr_ptr,
  output logic [PWIDTH-1:0] rd_ptr,
  output logic [CWIDTH-1:0] count
);

  logic [PWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic              not_empty;
  logic              pop;

  assign not_empty   = (count_q != '0);
  assign fetch_ready = (count_q != CWIDTH'(DEPTH));

`ifdef INSN_QUEUE_BYPASS_EN
  assign bypass = !not_empty && fetch_valid && dec_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed pair is consumed directly by decode and never occupies a slot.
  assign push      = fetch_valid && fetch_ready && !flush && !bypass;
  assign pop       = not_empty && dec_ready && !flush;
  assign dec_valid = (not_empty && !flush) || bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/insn_queue.sv
// Fetch-to-decode instruction FIFO: storage array and decode output muxing.
// Define INSN_QUEUE_BYPASS_EN for a combinational pass-through when empty.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4,
  parameter int CWIDTH = $clog2(DEPTH) + 1
) (
  input logic        clk,
  input logic        rst,
  insn_queue_if.slave bus
);

  localparam int PWIDTH = $clog2(DEPTH);

  logic              push;
  logic              bypass;
  logic              fetch_ready;
  logic              dec_valid;
  logic [PWIDTH-1:0] wr_ptr;
  logic [PWIDTH-1:0] rd_ptr;
  logic [CWIDTH-1:0] count;

  logic [AWIDTH-1:0] pc_mem_q   [DEPTH];
  logic [AWIDTH-1:0] pc_mem_d   [DEPTH];
  logic [DWIDTH-1:0] insn_mem_q [DEPTH];
  logic [DWIDTH-1:0] insn_mem_d [DEPTH];
  logic [AWIDTH-1:0] dec_pc;
  logic [DWIDTH-1:0] dec_insn;

  insn_queue_ctrl #(
    .DEPTH  (DEPTH),
    .PWIDTH (PWIDTH),
    .CWIDTH (CWIDTH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (bus.fetch_valid_i),
    .dec_ready   (bus.dec_ready_i),
    .flush       (bus.flush_i),
    .push        (push),
    .bypass      (bypass),
    .fetch_ready (fetch_ready),
    .dec_valid   (dec_valid),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count)
  );

  always_comb begin
    pc_mem_d   = pc_mem_q;
    insn_mem_d = insn_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr]   = bus.fetch_pc_i;
      insn_mem_d[wr_ptr] = bus.fetch_insn_i;
    end
  end

  // Storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    insn_mem_q <= insn_mem_d;
  end

  always_comb begin
    dec_pc   = '0;
    dec_insn = DWIDTH'(INSN_NOP);
    if (bypass) begin
      dec_pc   = bus.fetch_pc_i;
      dec_insn = bus.fetch_insn_i;
    end else if (count != '0) begin
      dec_pc   = pc_mem_q[rd_ptr];
      dec_insn = insn_mem_q[rd_ptr];
    end
  end

  assign bus.fetch_ready_o = fetch_ready;
  assign bus.dec_valid_o   = dec_valid;
  assign bus.dec_pc_o      = dec_pc;
  assign bus.dec_insn_o    = dec_insn;
  assign bus.count_o       = count;

endmodule

// File: tb/tb_insn_queue.sv
// Randomised scoreboard bench for insn_queue against a queue-based reference model.
// Honours INSN_QUEUE_BYPASS_EN in the same way as the design.
module tb_insn_queue;
  import insn_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef INSN_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  insn_queue_if #(.DEPTH(DEPTH)) bus ();

  insn_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_pkt_t model_q [$];
  fetch_pkt_t exp_q   [$];

  int          exp_count;
  bit          exp_ready;
  bit          exp_valid;
  bit          exp_head_chk;
  logic [31:0] exp_head_pc;
  logic [31:0] exp_head_insn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus from posedge+1, predict, check mid-cycle.
  task automatic applyStimulus(input bit fv, input logic [31:0] pc, input logic [31:0] insn,
                               input bit dr, input bit fl);
    int         sz;
    bit         byp;
    fetch_pkt_t pkt;
    bus.fetch_valid_i = fv;
    bus.fetch_pc_i    = pc;
    bus.fetch_insn_i  = insn;
    bus.dec_ready_i   = dr;
    bus.flush_i       = fl;
    pkt.pc   = pc;
    pkt.insn = insn;
    sz  = model_q.size();
    byp = BYP && sz == 0 && fv && dr && !fl;
    exp_count    = sz;
    exp_ready    = (sz != DEPTH);
    exp_valid    = byp || (sz != 0 && !fl);
    exp_head_chk = byp || sz != 0;
    exp_head_pc   = byp ? pc   : (sz != 0 ? model_q[0].pc   : 32'h0);
    exp_head_insn = byp ? insn : (sz != 0 ? model_q[0].insn : INSN_NOP);
    if (fl) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      if (byp) exp_q.push_back(pkt);
      if (sz != 0 && dr) void'(model_q.pop_front());
      if (fv && sz != DEPTH && !byp) begin
        model_q.push_back(pkt);
        exp_q.push_back(pkt);
      end
    end
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    check("count", 64'(bus.count_o), 64'(exp_count));
    check("fetch_ready", 64'(bus.fetch_ready_o), 64'(exp_ready));
    check("dec_valid", 64'(bus.dec_valid_o), 64'(exp_valid));
    if (exp_head_chk || !exp_valid) begin
      if (exp_head_chk && !exp_valid) begin
        // head is present but masked by flush; contents are don't-care
      end else begin
        check("dec_pc", 64'(bus.dec_pc_o), 64'(exp_head_pc));
        check("dec_insn", 64'(bus.dec_insn_o), 64'(exp_head_insn));
      end
    end
  endtask

  // Scoreboard monitor: every accepted decode handshake must match the oldest expectation.
  initial begin
    fetch_pkt_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.dec_valid_o && bus.dec_ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop_pc", 64'(bus.dec_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", 64'(bus.dec_pc_o), 64'(e.pc));
          check("sb_insn", 64'(bus.dec_insn_o), 64'(e.insn));
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    bus.fetch_valid_i = 1'b0;
    bus.fetch_pc_i    = '0;
    bus.fetch_insn_i  = '0;
    bus.dec_ready_i   = 1'b0;
    bus.flush_i       = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_count", 64'(bus.count_o), 64'd0);
    check("rst_fetch_ready", 64'(bus.fetch_ready_o), 64'd1);
    check("rst_dec_valid", 64'(bus.dec_valid_o), 64'd0);
    check("rst_dec_pc", 64'(bus.dec_pc_o), 64'd0);
    check("rst_dec_insn", 64'(bus.dec_insn_o), 64'(INSN_NOP));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // idle, then two pushes held by decode, then drained in order
    applyStimulus(0, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, IMEM_BASE_ADDR, 32'h0050_0093, 0, 0);
    applyStimulus(1, IMEM_BASE_ADDR + 32'd4, 32'h00A0_0113, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // fill to full, then offer a 5th pair while popping
    for (int k = 0; k < 4; k++)
      applyStimulus(1, IMEM_BASE_ADDR + 32'h40 + 32'(4 * k), 32'h1000_0000 + 32'(k), 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, IMEM_BASE_ADDR + 32'h50, 32'hDEAD_0005, 1, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // streaming push+pop with pointer wrap
    applyStimulus(1, IMEM_BASE_ADDR, 32'h2000_0000, 0, 0);
    for (int k = 1; k <= 10; k++)
      applyStimulus(1, IMEM_BASE_ADDR + 32'(4 * k), 32'h2000_0000 + 32'(k), 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0);

    // flush with a simultaneous push
    for (int k = 0; k < 3; k++)
      applyStimulus(1, IMEM_BASE_ADDR + 32'h80 + 32'(4 * k), 32'h3000_0000 + 32'(k), 0, 0);
    applyStimulus(1, IMEM_BASE_ADDR + 32'h100, 32'h3000_0100, 1, 1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // empty queue push with decode ready (pass-through when bypass is built in)
    applyStimulus(1, IMEM_BASE_ADDR + 32'h8, 32'h0000_0073, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // randomised traffic
    pc = IMEM_BASE_ADDR + 32'h200;
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), pc, $urandom, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0));
      pc = pc + 32'd4;
    end
    for (int k = 0; k < DEPTH + 1; k++) applyStimulus(0, 32'h0, 32'h0, 1, 0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
